// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port unified memory between the IF (fetch) and MEM (load/store) stages.
// Data wins by default; a streak counter bounds fetch starvation and a watchdog aborts hung accesses.
module unified_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [XLEN-1:0]     i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  input  logic [XLEN/8-1:0]   d_be,
  output logic                d_ack,
  output logic [XLEN-1:0]     d_rdata,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_ready,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          busy;
  logic          timed_out;
  logic          done;
  logic          fetch_due;
  logic          grant_d;

  assign busy      = (state == BUSY_I) || (state == BUSY_D);
  assign timed_out = busy && !mem_ready && (timer == TIMER_LAST);
  // A transaction caught by reset is dropped, so its ack is suppressed in the reset cycle.
  assign done      = busy && (mem_ready || timed_out) && !rst;

  assign i_ack   = done && (state == BUSY_I);
  assign d_ack   = done && (state == BUSY_D);
  assign i_rdata = (i_ack && mem_ready) ? mem_rdata : '0;
  assign d_rdata = (d_ack && mem_ready) ? mem_rdata : '0;

  assign stall_if  = i_req && !i_ack;
  assign stall_mem = d_req && !d_ack;

  assign fetch_due = i_req && (streak == STREAK_MAX);
  assign grant_d   = d_req && !fetch_due;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      timer     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_we ? d_be : '1;
            if (!i_req)
              streak <= '0;
            else if (streak != STREAK_MAX)
              streak <= streak + SW'(1);
          end else if (i_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            streak    <= '0;
          end else begin
            streak <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready || timed_out) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (timed_out)
              err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed transactions against a behavioural memory and a
// transaction-level reference model checked on every cycle.
module tb_unified_mem_arbiter;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int MAXS    = 4;
  localparam int TMO     = 64;
  localparam int BOUND   = 200;
  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_D = 8'h44;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_ack;
  logic [ADDR_W-1:0] i_addr;
  logic [XLEN-1:0]   i_rdata;
  logic              d_req, d_we, d_ack;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata, d_rdata;
  logic [3:0]        d_be;
  logic              stall_if, stall_mem;
  logic              mem_req, mem_we, mem_ready, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;
  logic [3:0]        mem_be;

  unified_mem_arbiter #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name, input int waited);
    checks++;
    errors++;
    $display("FAIL %s: no ack after %0d cycles, required within %0d", name, waited, BOUND);
  endtask

  // Behavioural memory: responds lat cycles after mem_req rises, optional spurious pulses in idle.
  logic [31:0] ram    [256];
  logic [31:0] shadow [256];
  int  lat = 0;
  int  cnt = 0;
  bit  fired = 0;
  bit  force_rdy = 0;
  bit  spur = 0;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (!mem_req) begin
        cnt = 0;
        fired = 0;
        if (force_rdy || (spur && ($urandom % 3 == 0))) mem_ready = 1'b1;
      end else if (!fired && cnt >= lat) begin
        mem_ready = 1'b1;
        fired = 1;
        mem_rdata = ram[mem_addr[9:2]];
      end else begin
        cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_req && mem_ready && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference model: who owns the memory, how long it has been waiting, how many data wins
  // in a row a waiting fetch has suffered, and the fields latched for the memory.
  int          own = 0;     // 0 none, 1 fetch, 2 data
  int          age = 0;
  int          dwins = 0;
  bit          sticky = 0;
  bit          armed = 0;
  logic        f_we = 0;
  logic [31:0] f_addr = 0, f_wdata = 0;
  logic [3:0]  f_be = 0;
  bit          fin, fin_to, e_iack, e_dack;

  always @(negedge clk) begin
    fin_to = (own != 0) && !mem_ready && (age == TMO - 1);
    fin    = (own != 0) && (mem_ready || fin_to) && !rst;
    e_iack = fin && (own == 1);
    e_dack = fin && (own == 2);
    if (armed) begin
      chk("mem_req",   mem_req,   own != 0);
      chk("mem_we",    mem_we,    f_we);
      chk("mem_addr",  mem_addr,  f_addr);
      chk("mem_wdata", mem_wdata, f_wdata);
      chk("mem_be",    mem_be,    f_be);
      chk("i_ack",     i_ack,     e_iack);
      chk("d_ack",     d_ack,     e_dack);
      chk("stall_if",  stall_if,  i_req && !e_iack);
      chk("stall_mem", stall_mem, d_req && !e_dack);
      chk("err",       err,       sticky);
      if (e_iack) chk("i_rdata", i_rdata, mem_ready ? mem_rdata : 32'h0);
      if (e_dack) chk("d_rdata", d_rdata, mem_ready ? mem_rdata : 32'h0);
    end
    if (rst) begin
      own = 0; age = 0; dwins = 0; sticky = 0;
      f_we = 0; f_addr = 0; f_wdata = 0; f_be = 0;
      armed = 1;
    end else if (own == 0) begin
      age = 0;
      if (d_req && !(i_req && dwins >= MAXS)) begin
        own = 2; f_we = d_we; f_addr = d_addr; f_wdata = d_wdata;
        f_be = d_we ? d_be : 4'hF;
        dwins = i_req ? dwins + 1 : 0;
      end else begin
        if (i_req) begin
          own = 1; f_we = 0; f_addr = i_addr; f_wdata = 0; f_be = 4'hF;
        end
        dwins = 0;
      end
    end else if (mem_ready || fin_to) begin
      own = 0;
      if (fin_to) sticky = 1;
    end else begin
      age++;
    end
  end

  // Requesters: called at posedge+1, return at posedge+1 just after the ack edge.
  logic [7:0] order [$];

  task automatic fetch(input logic [31:0] a, output logic [31:0] data, output int n);
    i_req = 1'b1; i_addr = a; n = 0; data = '0;
    forever begin
      @(negedge clk); n++;
      if (i_ack) begin data = i_rdata; order.push_back(CH_I); break; end
      if (n >= BOUND) begin bound_fail("fetch_wait", n); break; end
    end
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] data, output int n);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be; n = 0; data = '0;
    forever begin
      @(negedge clk); n++;
      if (d_ack) begin data = d_rdata; order.push_back(CH_D); break; end
      if (n >= BOUND) begin bound_fail("data_wait", n); break; end
    end
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic shadow_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) shadow[a[9:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  logic [31:0] r1, r2, wd;
  logic [3:0]  be;
  int          n1, n2, widx, fidx;
  logic [7:0]  exp_ord [8];

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'hC0DE0000 ^ (i * 32'h00010203);
      shadow[i] = ram[i];
    end
    ram[4] = 32'h12345678;
    shadow[4] = 32'h12345678;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_acks", {i_ack, d_ack}, 2'b00);

    // Single fetch, zero memory latency
    @(posedge clk); #1;
    lat = 0;
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    chk("t1_stall_c0", stall_if, 1'b1);
    chk("t1_memreq_c0", mem_req, 1'b0);
    @(negedge clk);
    chk("t1_addr_c1", mem_addr, 32'h10);
    chk("t1_we_c1", mem_we, 1'b0);
    chk("t1_ack_c1", i_ack, 1'b1);
    chk("t1_rdata_c1", i_rdata, 32'h12345678);
    chk("t1_stall_c1", stall_if, 1'b0);
    @(posedge clk); #1;
    i_req = 1'b0;

    // Simultaneous store and fetch: data first, fetch stalls through both
    lat = 2;
    order.delete();
    fork
      fetch(32'h24, r1, n1);
      dacc(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, r2, n2);
    join
    shadow_write(32'h100, 32'hDEADBEEF, 4'hF);
    chk("t2_order_len", order.size(), 2);
    chk("t2_first_D", order[0], CH_D);
    chk("t2_fetch_cycles", n1, 8);
    chk("t2_store_cycles", n2, 4);
    chk("t2_fetch_data", r1, shadow[9]);
    chk("t2_ram_written", ram[64], 32'hDEADBEEF);

    // Continuous data traffic against a waiting fetch stream
    lat = 1;
    order.delete();
    exp_ord = '{CH_D, CH_D, CH_D, CH_D, CH_I, CH_D, CH_D, CH_I};
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          dacc(1'b0, 32'h200 + 32'(k * 4), 32'h0, 4'h0, r2, n2);
          chk("t3_load", r2, shadow[128 + k]);
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          fetch(32'h40 + 32'(k * 4), r1, n1);
          chk("t3_fetch", r1, shadow[16 + k]);
        end
      end
    join
    chk("t3_order_len", order.size(), 8);
    for (int k = 0; k < 8; k++) chk("t3_order", order[k], exp_ord[k]);

    // Watchdog: memory never answers
    lat = 1000;
    fetch(32'h30, r1, n1);
    chk("t4_ack_cycle", n1, TMO + 1);
    chk("t4_rdata_zero", r1, 32'h0);
    chk("t4_err_set", err, 1'b1);
    lat = 1;
    dacc(1'b0, 32'h30, 32'h0, 4'h0, r2, n2);
    chk("t4_after_data", r2, shadow[12]);
    chk("t4_err_sticky", err, 1'b1);

    // Reset in the middle of a data access, then a late ready
    lat = 1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    repeat (3) @(negedge clk);
    chk("t5_busy_before_rst", mem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    chk("t5_no_ack_in_rst", d_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; force_rdy = 1'b1;
    @(negedge clk);
    chk("t5_no_late_ack", d_ack, 1'b0);
    chk("t5_mem_req_low", mem_req, 1'b0);
    chk("t5_err_cleared", err, 1'b0);
    @(posedge clk); #1;
    force_rdy = 1'b0; lat = 0;
    dacc(1'b0, 32'h8, 32'h0, 4'h0, r2, n2);
    chk("t5_idle_latency", n2, 2);
    chk("t5_data", r2, shadow[2]);

    // Latency sweep over mixed traffic with spurious idle ready pulses
    spur = 1;
    for (int k = 0; k < 20; k++) begin
      lat  = k % 11;
      widx = (k * 3) % 16;
      fidx = (k * 5) % 16;
      case (k % 4)
        0: begin
          wd = $urandom;
          be = 4'(k | 1);
          dacc(1'b1, 32'(widx * 4), wd, be, r2, n2);
          shadow_write(32'(widx * 4), wd, be);
        end
        1: begin
          dacc(1'b0, 32'(((k - 1) * 3 % 16) * 4), 32'h0, 4'h0, r2, n2);
          chk("sweep_load", r2, shadow[(k - 1) * 3 % 16]);
        end
        2: begin
          fetch(32'(fidx * 4), r1, n1);
          chk("sweep_fetch", r1, shadow[fidx]);
        end
        default: begin
          fork
            fetch(32'(fidx * 4), r1, n1);
            dacc(1'b0, 32'(widx * 4), 32'h0, 4'h0, r2, n2);
          join
          chk("sweep_pair_fetch", r1, shadow[fidx]);
          chk("sweep_pair_load", r2, shadow[widx]);
        end
      endcase
    end
    spur = 0;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
